gobou_serializer: RTL and testbench

//   Parametrised parallel-to-serial converter for the gobou output path.

---
 rtl/gobou_serializer_if.sv | 27 ++
 rtl/gobou_serializer.sv | 112 +++++++++++
 tb/tb_gobou_serializer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gobou_serializer_if.sv
// Stream bundle for gobou_serializer: parallel vector in, one word per beat out.
// The slave modport is the serializer's view; master is the environment's.
interface gobou_serializer_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned LANES  = 16,
    parameter int unsigned CWIDTH = $clog2(LANES + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*DWIDTH-1:0]  in_data;
    logic [CWIDTH-1:0]        in_count;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out_data;
    logic [CWIDTH-1:0]        out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_count, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/gobou_serializer.sv
// Parallel-to-serial converter: captures LANES signed words in one cycle and
// emits them lane 0 first on a valid/ready stream, with flush and partial vectors.
module gobou_serializer #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned LANES  = 16,
    parameter int unsigned CWIDTH = $clog2(LANES + 1)
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              flush,
    output logic              busy,
    gobou_serializer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                   state_q, state_d;
    logic signed [DWIDTH-1:0] lane_q [LANES];
    logic signed [DWIDTH-1:0] lane_d [LANES];
    logic [CWIDTH-1:0]        remain_q, remain_d;
    logic [CWIDTH-1:0]        idx_q, idx_d;
    logic [CWIDTH-1:0]        cnt_eff;

    logic out_valid;
    logic out_last;
    logic in_ready;
    logic load;
    logic advance;
    logic finish;

    // Zero or out-of-range counts mean a full vector.
    always_comb begin
        cnt_eff = bus.in_count;
        if (bus.in_count == '0 || bus.in_count > CWIDTH'(LANES)) begin
            cnt_eff = CWIDTH'(LANES);
        end
    end

    assign out_valid = (state_q == StShift);
    assign out_last  = out_valid && (remain_q == CWIDTH'(1));
    assign in_ready  = !flush && ((state_q == StIdle) || (out_valid && bus.out_ready && out_last));

    assign load    = bus.in_valid && in_ready;
    assign advance = out_valid && bus.out_ready && !out_last;
    assign finish  = out_valid && bus.out_ready && out_last;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = lane_q[0];
    assign bus.out_idx   = idx_q;
    assign busy          = out_valid;

    // Flush beats load, load beats shift; load during the last beat skips IDLE.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i];
        end

        if (flush) begin
            state_d  = StIdle;
            remain_d = '0;
            idx_d    = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_d[i] = '0;
            end
        end else if (load) begin
            state_d  = StShift;
            remain_d = cnt_eff;
            idx_d    = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_d[i] = bus.in_data[i*DWIDTH +: DWIDTH];
            end
        end else if (advance) begin
            remain_d = remain_q - CWIDTH'(1);
            idx_d    = idx_q + CWIDTH'(1);
            for (int unsigned i = 0; i < LANES - 1; i++) begin
                lane_d[i] = lane_q[i+1];
            end
            lane_d[LANES-1] = '0;
        end else if (finish) begin
            state_d  = StIdle;
            remain_d = '0;
            idx_d    = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q  <= StIdle;
            remain_q <= '0;
            idx_q    <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gobou_serializer.sv
// Scoreboard bench for gobou_serializer: expected beats are queued on load
// and popped as the stream delivers them.
module tb_gobou_serializer;

    typedef struct packed {
        logic signed [15:0] data;
        logic [4:0]         idx;
        logic               last;
    } exp_t;

    logic clk;
    logic xrst;
    logic flush;
    logic busy;

    int n_checks;
    int n_fail;

    exp_t               sb [$];
    logic signed [15:0] vec [16];

    gobou_serializer_if #(.DWIDTH(16), .LANES(16)) bus ();

    gobou_serializer #(.DWIDTH(16), .LANES(16)) dut (
        .clk  (clk),
        .xrst (xrst),
        .flush(flush),
        .busy (busy),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_vec(input int cnt);
        for (int i = 0; i < 16; i++) bus.in_data[i*16 +: 16] = vec[i];
        bus.in_count = 5'(cnt);
        bus.in_valid = 1'b1;
    endtask

    task automatic push_vec(input int cnt);
        int   n;
        exp_t e;
        n = (cnt == 0 || cnt > 16) ? 16 : cnt;
        for (int i = 0; i < n; i++) begin
            e.data = vec[i];
            e.idx  = 5'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_idx !== 5'd0 ||
            bus.out_last !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%0d idx=%0d last=%b busy=%b in_ready=%b, required 0 0 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, busy, bus.in_ready);
        end
        @(negedge clk);
        xrst = 1'b1;
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 16; i++) vec[i] = 16'(i + 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(16);
        push_vec(16);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            if (bus.out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL full_beat: data=%0d idx=%0d last=%b, required %0d %0d %b",
                             bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                end
                n_checks++;
                if (bus.in_ready !== e.last) begin
                    n_fail++;
                    $display("FAIL full_in_ready: in_ready=%b, required %b", bus.in_ready, e.last);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end: pending=%0d out_valid=%b, required 0 0", sb.size(), bus.out_valid);
            sb.delete();
        end
    endtask

    task automatic test_partial();
        int   cnts [3];
        exp_t e;
        cnts = '{3, 0, 20};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
            if (k == 0) begin
                vec[0] = 16'sd7;
                vec[1] = -16'sd2;
                vec[2] = 16'sd5;
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive_vec(cnts[k]);
            push_vec(cnts[k]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
                if (bus.out_valid) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL partial_beat cnt=%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                                 cnts[k], bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                    end
                end
                @(negedge clk);
            end
            n_checks++;
            if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL partial_end cnt=%0d: pending=%0d out_valid=%b, required 0 0",
                         cnts[k], sb.size(), bus.out_valid);
                sb.delete();
            end
        end
    endtask

    task automatic test_backpressure();
        logic               pat [4];
        logic               held;
        logic signed [15:0] hd;
        logic [4:0]         hi;
        exp_t               e;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        held = 1'b0;
        for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(10);
        push_vec(10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 80 && sb.size() > 0; cyc++) begin
            if (held) begin
                held = 1'b0;
                n_checks++;
                if (bus.out_data !== hd || bus.out_idx !== hi || bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold: data=%0d idx=%0d valid=%b, required %0d %0d 1",
                             bus.out_data, bus.out_idx, bus.out_valid, hd, hi);
                end
            end
            bus.out_ready = pat[cyc % 4];
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL bp_beat: data=%0d idx=%0d last=%b, required %0d %0d %b",
                                 bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                    end
                end else begin
                    held = 1'b1;
                    hd   = sb[0].data;
                    hi   = sb[0].idx;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: pending=%0d out_valid=%b, required 0 0", sb.size(), bus.out_valid);
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic b_pushed;
        logic chk_bubble;
        b_pushed   = 1'b0;
        chk_bubble = 1'b0;
        for (int i = 0; i < 16; i++) vec[i] = 16'(100 + i);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(4);
        push_vec(4);
        @(negedge clk);
        for (int i = 0; i < 16; i++) vec[i] = 16'(-50 - i);
        drive_vec(3);
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            if (b_pushed) bus.in_valid = 1'b0;
            if (chk_bubble) begin
                chk_bubble = 1'b0;
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd0) begin
                    n_fail++;
                    $display("FAIL b2b_no_bubble: valid=%b idx=%0d, required 1 0", bus.out_valid, bus.out_idx);
                end
            end
            if (bus.out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL b2b_beat: data=%0d idx=%0d last=%b, required %0d %0d %b",
                             bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                end
                if (!b_pushed) begin
                    n_checks++;
                    if (bus.in_ready !== e.last) begin
                        n_fail++;
                        $display("FAIL b2b_in_ready: in_ready=%b, required %b", bus.in_ready, e.last);
                    end
                    if (e.last) begin
                        push_vec(3);
                        b_pushed   = 1'b1;
                        chk_bubble = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0 || !b_pushed) begin
            n_fail++;
            $display("FAIL b2b_end: pending=%0d out_valid=%b b_loaded=%b, required 0 0 1",
                     sb.size(), bus.out_valid, b_pushed);
            sb.delete();
        end
    endtask

    task automatic test_flush();
        exp_t e;
        for (int i = 0; i < 16; i++) vec[i] = 16'(200 + i);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(16);
        push_vec(16);
        @(negedge clk);
        for (int i = 0; i < 16; i++) vec[i] = 16'(-300 - i);
        drive_vec(2);
        for (int b = 0; b < 4; b++) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_data !== e.data || bus.out_idx !== e.idx) begin
                n_fail++;
                $display("FAIL flush_pre_beat: in_ready=%b data=%0d idx=%0d, required 0 %0d %0d",
                         bus.in_ready, bus.out_data, bus.out_idx, e.data, e.idx);
            end
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_idx !== 5'd4) begin
            n_fail++;
            $display("FAIL flush_in_ready: in_ready=%b idx=%0d, required 0 4", bus.in_ready, bus.out_idx);
        end
        sb.delete();
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== 5'd0 || bus.out_data !== 16'sd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: valid=%b idx=%0d data=%0d busy=%b, required 0 0 0 0",
                     bus.out_valid, bus.out_idx, bus.out_data, busy);
        end
        drive_vec(2);
        push_vec(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            if (bus.out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL flush_reload: data=%0d idx=%0d last=%b, required %0d %0d %b",
                             bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: pending=%0d out_valid=%b, required 0 0", sb.size(), bus.out_valid);
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) vec[i] = 16'(40 + i);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(16);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd3) begin
            n_fail++;
            $display("FAIL areset_pre: valid=%b idx=%0d, required 1 3", bus.out_valid, bus.out_idx);
        end
        #2 xrst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: valid=%b data=%0d in_ready=%b busy=%b, required 0 0 1 0",
                     bus.out_valid, bus.out_data, bus.in_ready, busy);
        end
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL areset_after: valid=%b idx=%0d, required 0 0", bus.out_valid, bus.out_idx);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        xrst          = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_count  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
